// File: rtl/multi_alarm_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multi_alarm_ctrl : N-slot alarm controller with shared stop/snooze buttons
// Revision 1.0
// ---------------------------------------------------------------------------
module multi_alarm_ctrl #(
  parameter int N_ALARM    = 4,
  parameter int SEC_W      = 17,
  parameter int DAY_SEC    = 86400,
  parameter int LEN_W      = 6,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  localparam int IDX_W     = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_i,
  input  logic [SEC_W-1:0]   cur_sec_i,
  input  logic               cfg_we_i,
  input  logic [IDX_W-1:0]   cfg_idx_i,
  input  logic [SEC_W-1:0]   cfg_sec_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_en_i,
  input  logic               stop_btn_i,
  input  logic               snooze_btn_i,
  output logic               sound_o,
  output logic [N_ALARM-1:0] ringing_o,
  output logic               active_valid_o,
  output logic [IDX_W-1:0]   active_idx_o
);

  localparam int CNT_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SNOOZE);
  localparam logic [SEC_W:0]   SNZ_ADD = (SEC_W + 1)'(SNOOZE_SEC);
  localparam logic [SEC_W:0]   DAY_EXT = (SEC_W + 1)'(DAY_SEC);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RINGING = 2'd1,
    S_SNOOZED = 2'd2
  } state_e;

  logic             stop_q, snooze_q;
  logic             stop_edge, snooze_edge;
  logic             sec_ok;
  logic [SEC_W:0]   snz_sum;
  logic [SEC_W:0]   snz_red;
  logic [SEC_W-1:0] snz_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      stop_q   <= 1'b0;
      snooze_q <= 1'b0;
    end else begin
      stop_q   <= stop_btn_i;
      snooze_q <= snooze_btn_i;
    end
  end

  assign stop_edge   = stop_btn_i & ~stop_q;
  assign snooze_edge = snooze_btn_i & ~snooze_q;

  // Out-of-day seconds must never alias onto a stored target.
  assign sec_ok     = ({1'b0, cur_sec_i} < DAY_EXT);
  assign snz_sum    = {1'b0, cur_sec_i} + SNZ_ADD;
  assign snz_red    = (snz_sum >= DAY_EXT) ? (snz_sum - DAY_EXT) : snz_sum;
  assign snz_target = snz_red[SEC_W-1:0];

  generate
    for (genvar i = 0; i < N_ALARM; i++) begin : g_slot
      state_e           state_q, state_d;
      logic             en_q, en_d;
      logic [SEC_W-1:0] tgt_q, tgt_d, snz_sec_q, snz_sec_d;
      logic [LEN_W-1:0] len_q, len_d, remain_q, remain_d;
      logic [CNT_W-1:0] snz_cnt_q, snz_cnt_d;
      logic             cfg_hit, serviced;

      assign cfg_hit  = cfg_we_i && (cfg_idx_i == IDX_W'(i));
      // active_idx is derived from the pre-edge state, so a press only
      // reaches a slot that was already ringing.
      assign serviced = active_valid_o && (active_idx_o == IDX_W'(i)) &&
                        (stop_edge || snooze_edge);

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q   <= S_IDLE;
          en_q      <= 1'b0;
          tgt_q     <= '0;
          len_q     <= '0;
          remain_q  <= '0;
          snz_sec_q <= '0;
          snz_cnt_q <= '0;
        end else begin
          state_q   <= state_d;
          en_q      <= en_d;
          tgt_q     <= tgt_d;
          len_q     <= len_d;
          remain_q  <= remain_d;
          snz_sec_q <= snz_sec_d;
          snz_cnt_q <= snz_cnt_d;
        end
      end

      always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        tgt_d     = tgt_q;
        len_d     = len_q;
        remain_d  = remain_q;
        snz_sec_d = snz_sec_q;
        snz_cnt_d = snz_cnt_q;
        if (cfg_hit) begin
          en_d      = cfg_en_i;
          tgt_d     = cfg_sec_i;
          len_d     = cfg_len_i;
          state_d   = S_IDLE;
          snz_cnt_d = '0;
        end else if (serviced) begin
          if (stop_edge || (snz_cnt_q >= MAX_CNT)) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_SNOOZED;
            snz_sec_d = snz_target;
            snz_cnt_d = snz_cnt_q + 1'b1;
          end
        end else if (tick_i) begin
          case (state_q)
            S_IDLE: begin
              if (en_q && sec_ok && (cur_sec_i == tgt_q)) begin
                state_d   = S_RINGING;
                remain_d  = len_q;
                snz_cnt_d = '0;
              end
            end
            S_SNOOZED: begin
              if (sec_ok && (cur_sec_i == snz_sec_q)) begin
                state_d  = S_RINGING;
                remain_d = len_q;
              end else if (!en_q) begin
                state_d = S_IDLE;
              end
            end
            S_RINGING: begin
              // A zero length rings until a button services the slot.
              if (len_q != '0) begin
                if (remain_q == LEN_W'(1)) state_d = S_IDLE;
                else                       remain_d = remain_q - 1'b1;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end

      assign ringing_o[i] = (state_q == S_RINGING);
    end
  endgenerate

  always_comb begin
    active_idx_o = '0;
    for (int k = N_ALARM - 1; k >= 0; k--) begin
      if (ringing_o[k]) active_idx_o = IDX_W'(k);
    end
  end

  assign active_valid_o = |ringing_o;
  assign sound_o        = |ringing_o;

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_ctrl.sv
`default_nettype none
// tb_multi_alarm_ctrl: directed stimulus with a queue-based scoreboard and
// an independent negedge monitor that compares every queued expectation.
module tb_multi_alarm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [16:0] cur_sec;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [16:0] cfg_sec;
  logic [5:0]  cfg_len;
  logic        cfg_en;
  logic        stop_btn;
  logic        snooze_btn;
  logic        sound;
  logic [3:0]  ringing;
  logic        active_valid;
  logic [1:0]  active_idx;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string      name;
    logic [3:0] ring;
    logic [1:0] idx;
  } exp_t;

  exp_t exp_q[$];

  multi_alarm_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .tick_i         (tick),
    .cur_sec_i      (cur_sec),
    .cfg_we_i       (cfg_we),
    .cfg_idx_i      (cfg_idx),
    .cfg_sec_i      (cfg_sec),
    .cfg_len_i      (cfg_len),
    .cfg_en_i       (cfg_en),
    .stop_btn_i     (stop_btn),
    .snooze_btn_i   (snooze_btn),
    .sound_o        (sound),
    .ringing_o      (ringing),
    .active_valid_o (active_valid),
    .active_idx_o   (active_idx)
  );

  always #5 clk = ~clk;

  // Monitor: drains the scoreboard on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({sound, active_valid, active_idx, ringing} !==
            {|e.ring, |e.ring, e.idx, e.ring}) begin
          n_miss++;
          $display("FAIL %s: got sound=%b valid=%b idx=%0d ringing=%b, want sound=%b valid=%b idx=%0d ringing=%b",
                   e.name, sound, active_valid, active_idx, ringing,
                   |e.ring, |e.ring, e.idx, e.ring);
        end
      end
    end
  end

  task automatic expect_out(input string name, input logic [3:0] ring, input logic [1:0] idx);
    exp_t e;
    e.name = name;
    e.ring = ring;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [3:0] ring, input logic [1:0] idx);
    n_vec++;
    if (sound !== |ring || active_valid !== |ring ||
        active_idx !== idx || ringing !== ring) begin
      n_miss++;
      $display("FAIL %s (direct): got sound=%b valid=%b idx=%0d ringing=%b, want ringing=%b idx=%0d",
               name, sound, active_valid, active_idx, ringing, ring, idx);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int s);
    cur_sec = 17'(s);
    tick    = 1'b1;
    step();
    tick    = 1'b0;
    step();
  endtask

  task automatic run_ticks(input int from, input int to);
    for (int s = from; s <= to; s++) do_tick(s);
  endtask

  task automatic cfg(input int idx, input int sec, input int len, input logic en);
    cfg_we  = 1'b1;
    cfg_idx = 2'(idx);
    cfg_sec = 17'(sec);
    cfg_len = 6'(len);
    cfg_en  = en;
    step();
    cfg_we  = 1'b0;
  endtask

  task automatic press(input logic st, input logic sn, input string name,
                       input logic [3:0] ring, input logic [1:0] idx);
    stop_btn   = st;
    snooze_btn = sn;
    step();
    expect_out(name, ring, idx);
    stop_btn   = 1'b0;
    snooze_btn = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; cur_sec = '0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_sec = '0; cfg_len = '0; cfg_en = 1'b0; stop_btn = 1'b0; snooze_btn = 1'b0;
    step(); step();
    check_now("reset_direct", 4'b0000, 2'd0);
    expect_out("reset", 4'b0000, 2'd0);
    rst = 1'b0;
    step();

    // Basic trigger and timeout: rings ticks 10..69, drops after tick 70.
    cfg(0, 10, 60, 1'b1);
    run_ticks(0, 9);
    expect_out("pre_trigger", 4'b0000, 2'd0);
    do_tick(10);
    expect_out("trigger", 4'b0001, 2'd0);
    run_ticks(11, 40);
    expect_out("mid_ring", 4'b0001, 2'd0);
    run_ticks(41, 69);
    expect_out("last_ring_tick", 4'b0001, 2'd0);
    do_tick(70);
    check_now("timeout_direct", 4'b0000, 2'd0);
    expect_out("timeout", 4'b0000, 2'd0);
    do_tick(71);
    expect_out("after_timeout", 4'b0000, 2'd0);

    // Stop mid-ring.
    cfg(0, 10, 60, 1'b1);
    run_ticks(0, 10);
    expect_out("retrigger", 4'b0001, 2'd0);
    run_ticks(11, 20);
    press(1'b1, 1'b0, "stop_mid", 4'b0000, 2'd0);
    run_ticks(21, 70);
    expect_out("stopped_70", 4'b0000, 2'd0);
    run_ticks(71, 75);
    expect_out("stopped_75", 4'b0000, 2'd0);

    // Snooze across midnight: 86300 + 300 wraps to 200.
    cfg(0, 10, 60, 1'b0);
    cfg(1, 86300, 0, 1'b1);
    do_tick(86299);
    expect_out("wrap_pre", 4'b0000, 2'd0);
    do_tick(86300);
    expect_out("wrap_trig", 4'b0010, 2'd1);
    press(1'b0, 1'b1, "wrap_snooze", 4'b0000, 2'd0);
    run_ticks(86301, 86399);
    run_ticks(0, 199);
    expect_out("snoozed_199", 4'b0000, 2'd0);
    do_tick(200);
    expect_out("rering_200", 4'b0010, 2'd1);
    run_ticks(201, 205);
    expect_out("len0_holds", 4'b0010, 2'd1);
    press(1'b1, 1'b0, "wrap_stop", 4'b0000, 2'd0);

    // Snooze limit: the fourth snooze acts as stop.
    cfg(2, 1000, 0, 1'b1);
    do_tick(1000);
    expect_out("lim_trig", 4'b0100, 2'd2);
    press(1'b0, 1'b1, "snooze1", 4'b0000, 2'd0);
    do_tick(1299);
    expect_out("snooze1_wait", 4'b0000, 2'd0);
    do_tick(1300);
    expect_out("rering1", 4'b0100, 2'd2);
    press(1'b0, 1'b1, "snooze2", 4'b0000, 2'd0);
    do_tick(1600);
    expect_out("rering2", 4'b0100, 2'd2);
    press(1'b0, 1'b1, "snooze3", 4'b0000, 2'd0);
    do_tick(1900);
    expect_out("rering3", 4'b0100, 2'd2);
    press(1'b0, 1'b1, "snooze4_stop", 4'b0000, 2'd0);
    do_tick(2200);
    expect_out("no_rering", 4'b0000, 2'd0);

    // Concurrent slots, priority, and stop beating snooze.
    cfg(2, 1000, 0, 1'b0);
    cfg(1, 50, 0, 1'b1);
    cfg(3, 50, 0, 1'b1);
    do_tick(50);
    expect_out("concurrent", 4'b1010, 2'd1);
    press(1'b1, 1'b0, "stop_low", 4'b1000, 2'd3);
    press(1'b1, 1'b0, "stop_high", 4'b0000, 2'd0);
    do_tick(50);
    expect_out("concurrent2", 4'b1010, 2'd1);
    press(1'b1, 1'b1, "stop_wins", 4'b1000, 2'd3);
    do_tick(350);
    expect_out("no_snooze_rering", 4'b1000, 2'd3);
    press(1'b1, 1'b0, "stop_slot3", 4'b0000, 2'd0);

    // Config write on a ringing slot, then reset mid-ring.
    do_tick(50);
    expect_out("concurrent3", 4'b1010, 2'd1);
    cfg(1, 50, 0, 1'b1);
    expect_out("cfg_forces_idle", 4'b1000, 2'd3);
    rst = 1'b1;
    step();
    expect_out("reset_mid_ring", 4'b0000, 2'd0);
    rst = 1'b0;
    step();

    // A press while idle must not stop a later trigger.
    cfg(0, 100, 5, 1'b1);
    stop_btn = 1'b1;
    step();
    expect_out("idle_press", 4'b0000, 2'd0);
    do_tick(100);
    expect_out("trig_after_idle_press", 4'b0001, 2'd0);
    stop_btn = 1'b0;
    step();
    expect_out("release_no_effect", 4'b0001, 2'd0);
    run_ticks(101, 104);
    expect_out("len5_last", 4'b0001, 2'd0);
    do_tick(105);
    expect_out("len5_end", 4'b0000, 2'd0);

    // Out-of-day seconds never match.
    cfg(2, 86400, 3, 1'b1);
    do_tick(86400);
    expect_out("out_of_day", 4'b0000, 2'd0);

    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    if (n_miss == 0) $display("PASS");
    else             $display("FAIL");
    $finish;
  end

endmodule
`default_nettype wire
